// File: rtl/relay_coil_driver.sv
// Relay coil sequencer: a full-strength pull-in, then a PWM economiser hold,
// then an enforced minimum-off release before the coil can be re-energised.
module relay_coil_driver #(
  parameter int counter_length_p = 16,
  parameter int pullin_cycles_p  = 1000,
  parameter int hold_period_p    = 20,
  parameter int hold_duty_p      = 8,
  parameter int min_off_cycles_p = 2000
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Request_i,
  input  logic       Enable_i,
  output logic       Coil_o,
  output logic       Closed_o,
  output logic       Busy_o,
  output logic [1:0] State_o
);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    PULLIN  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [counter_length_p-1:0] PULLIN_LAST = counter_length_p'(pullin_cycles_p - 1);
  localparam logic [counter_length_p-1:0] PERIOD_LAST = counter_length_p'(hold_period_p - 1);
  localparam logic [counter_length_p-1:0] HOLD_DUTY   = counter_length_p'(hold_duty_p);
  localparam logic [counter_length_p-1:0] MINOFF_LAST = counter_length_p'(min_off_cycles_p - 1);

  state_t                      state_reg;
  logic [counter_length_p-1:0] cnt_reg;
  logic [counter_length_p-1:0] pwm_next;
  logic                        coil_reg;
  logic                        closed_reg;
  logic                        busy_reg;

  // In HOLD the shared counter is the PWM phase; it wraps once per period.
  assign pwm_next = (cnt_reg == PERIOD_LAST) ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_reg  <= OFF;
      cnt_reg    <= '0;
      coil_reg   <= 1'b0;
      closed_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        OFF: begin
          if (Request_i && Enable_i) begin
            state_reg <= PULLIN;
            cnt_reg   <= '0;
            coil_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        PULLIN: begin
          // Losing the enable aborts pull-in at once; a dropped request does not.
          if (!Enable_i || (cnt_reg == PULLIN_LAST && !Request_i)) begin
            state_reg  <= RELEASE;
            cnt_reg    <= '0;
            coil_reg   <= 1'b0;
            closed_reg <= 1'b0;
            busy_reg   <= 1'b1;
          end else if (cnt_reg == PULLIN_LAST) begin
            state_reg  <= HOLD;
            cnt_reg    <= '0;
            coil_reg   <= (HOLD_DUTY != '0);
            closed_reg <= 1'b1;
            busy_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        HOLD: begin
          if (!Request_i || !Enable_i) begin
            state_reg  <= RELEASE;
            cnt_reg    <= '0;
            coil_reg   <= 1'b0;
            closed_reg <= 1'b0;
            busy_reg   <= 1'b1;
          end else begin
            cnt_reg  <= pwm_next;
            coil_reg <= (pwm_next < HOLD_DUTY);
          end
        end

        RELEASE: begin
          if (cnt_reg == MINOFF_LAST) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign Coil_o   = coil_reg;
  assign Closed_o = closed_reg;
  assign Busy_o   = busy_reg;
  assign State_o  = state_reg;

endmodule

// File: doc/relay_coil_driver.md
Name: relay_coil_driver

Overview:
- Downstream stage of the debounced relay-request block: consumes its stable, active-high request and drives the physical relay coil transistor.
- Sequences each activation through three phases:
  - a full-strength pull-in pulse;
  - a reduced-power PWM hold (coil economiser);
  - an enforced minimum-off release interval.
- Reports contact state to the rest of the design.

Parameters:
counter_length_p, 16, width of the shared phase counter; every cycle-count parameter must fit in it
pullin_cycles_p, 1000, cycles of continuous coil drive on activation (min 1)
hold_period_p, 20, PWM period in HOLD, in cycles (min 1)
hold_duty_p, 8, cycles per PWM period with coil high in HOLD (0..hold_period_p)
min_off_cycles_p, 2000, cycles the coil stays off after any de-energise before a new activation (min 1)

Ports:
Clk_i  input  1  system clock
Reset_i  input  1  reset; one clock; reset is synchronous and active-high
Request_i  input  1  stable relay request (high = close relay), driven by the debounce stage
Enable_i  input  1  global coil enable; low forces de-energise
Coil_o  output  1  coil drive, high = energised
Closed_o  output  1  high while contacts are held closed (HOLD state)
Busy_o  output  1  high in PULLIN or RELEASE (request changes not accepted)
State_o  output  2  current state code, for debug

Behaviour:
- All outputs registered. Reset (sampled on Clk_i) gives:
  - state OFF, counters 0;
  - Coil_o=0, Closed_o=0, Busy_o=0, State_o=0.
  - Reset wins over every other condition and aborts any phase immediately, including PULLIN or RELEASE.
- States and codes: OFF=0, PULLIN=1, HOLD=2, RELEASE=3.
- Outputs change on the same edge the FSM enters the new state.
- OFF:
  - Coil_o=0. On an edge with Request_i=1 and Enable_i=1, go to PULLIN and clear the counter.
- PULLIN:
  - Coil_o=1 continuously for exactly pullin_cycles_p cycles. Counter runs 0..pullin_cycles_p-1.
  - Request_i falling during PULLIN is ignored; the pull-in always completes (minimum on time).
  - At count pullin_cycles_p-1: go to HOLD if Request_i=1 and Enable_i=1, otherwise go to RELEASE.
  - Enable_i=0 at any PULLIN edge: go to RELEASE immediately (emergency de-energise).
- HOLD:
  - PWM counter starts at 0 on entry and wraps from hold_period_p-1 to 0.
  - Coil_o=1 when pwm_cnt < hold_duty_p. hold_duty_p=hold_period_p gives constant drive; hold_duty_p=0 gives coil low.
  - Closed_o=1 on every HOLD cycle.
  - Request_i=0 or Enable_i=0 on an edge: go to RELEASE, even mid-PWM period.
- RELEASE:
  - Coil_o=0, Closed_o=0. Coil stays low for exactly min_off_cycles_p cycles.
  - Requests are ignored during RELEASE.
  - At count min_off_cycles_p-1: go to OFF.
  - If Request_i=1 and Enable_i=1 while in OFF, PULLIN is entered on the next edge; no direct RELEASE-to-PULLIN path.
- Busy_o=1 exactly in PULLIN and RELEASE.
- Counter never exceeds the terminal value of its phase. No wrap beyond 2^counter_length_p is permitted; the parameter ranges above guarantee this.
- Request_i is not resynchronised; the upstream block is synchronous to Clk_i.

Test Plan (pullin_cycles_p=8, hold_period_p=4, hold_duty_p=2, min_off_cycles_p=6):
- Reset held 3 cycles with Request_i=1 -> Coil_o=0, State_o=0 throughout. First edge after release -> State_o=1, Coil_o=1.
- Request_i high, Enable_i high, steady -> Coil_o high 8 cycles, then HOLD with pattern 1,1,0,0 repeating and Closed_o=1. Busy_o high only during the 8 pull-in cycles.
- In HOLD, drop Request_i -> next edge State_o=3, Coil_o=0, Closed_o=0 for 6 cycles, then OFF.
  - Request_i re-asserted during RELEASE -> PULLIN starts exactly 1 cycle after OFF is entered.
- Request_i pulsed high for 2 cycles -> full 8-cycle pull-in, then RELEASE 6 cycles, then OFF. HOLD and Closed_o never seen.
- Enable_i dropped at pull-in cycle 3 -> Coil_o=0 on that edge, State_o=3, full 6-cycle RELEASE.
- Reset asserted mid-HOLD and mid-RELEASE -> OFF on that edge with all outputs 0. No residual min-off: a new request after reset starts PULLIN on the next edge.
